mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 256-bit off-chip data memory port between two cache requesters: port 0 is the instruction cache and port 1 is the data cache.
- Sits between the CPU's cache tops and the Data_Memory model.
- Handles one outstanding memory transaction at a time.
- Uses round-robin arbitration and routes acknowledge and read data back to the granted requester only.
- Includes a watchdog that flags a memory that never acknowledges.

Parameters:
ADDR_W, 32, address width of requester and memory ports
LINE_W, 256, cache-line data width
TIMEOUT_CYC, 64, cycles in a grant state without mem_ack_i before err_o sets; counter width is clog2(TIMEOUT_CYC+1)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
p0_enable_i  in  1  port 0 request; held high until p0_ack_o
p0_write_i  in  1  port 0: 1=write line, 0=read line
p0_addr_i  in  ADDR_W  port 0 line address
p0_data_i  in  LINE_W  port 0 write data
p0_data_o  out  LINE_W  port 0 read data, valid while p0_ack_o=1
p0_ack_o  out  1  port 0 transaction done, 1-cycle pulse
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o  (same as port 0, for port 1)
mem_enable_o  out  1  memory request, held until mem_ack_i
mem_write_o  out  1  memory write strobe
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  LINE_W  memory write data
mem_data_i  in  LINE_W  memory read data
mem_ack_i  in  1  memory done, 1-cycle pulse
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - err_o=0, timeout counter=0, both acks=0.
- States: IDLE, GRANT0, GRANT1.
- IDLE:
  - Only one enable high: grant that port.
  - Both high: grant the port not equal to last_grant.
  - Neither high: stay in IDLE.
  - On grant: register the winner's write/addr/data onto the mem_* outputs, set mem_enable_o=1, update last_grant, clear the counter.
  - Latency: request sampled at edge N, mem_enable_o=1 after edge N, i.e. 1 cycle.
- GRANTx:
  - mem_* outputs are held stable; requester inputs are not re-sampled.
  - mem_ack_i=1: px_ack_o=mem_ack_i combinationally in the same cycle, and px_data_o=mem_data_i. Next edge goes to IDLE with mem_enable_o=0 and mem_write_o=0.
  - Otherwise increment the counter, saturating at TIMEOUT_CYC.
- Mandatory dead cycle: at least one IDLE cycle between transactions, so a requester's enable (which drops the cycle after its ack) is never re-granted.
- Non-granted port: ack_o=0 always. data_o=mem_data_i is permitted but is don't-care while its ack is 0.
- Requester drops enable mid-grant (abort):
  - The memory transaction still completes.
  - The arbiter stays in GRANTx until mem_ack_i.
  - px_ack_o is suppressed for that transaction.
- mem_ack_i while in IDLE: ignored, no ack forwarded, err_o unchanged.
- Timeout: when the counter reaches TIMEOUT_CYC, err_o sets and stays set until reset. The arbiter keeps waiting for mem_ack_i; no forced abort.
- Reset mid-transaction: all state clears immediately. Memory side is abandoned; acks are not generated.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…; no port waits more than one transaction.

Test Plan:
1. Port-0 read only: p0_enable_i=1, write=0, addr=0x40. Memory acks 10 cycles later with data 0xA5…A5.
   -> mem_enable_o rises 1 cycle after the request with mem_addr_o=0x40; p0_ack_o pulses with p0_data_o=0xA5…A5; p1_ack_o stays 0.
2. Simultaneous request after reset: p0 read 0x100, p1 write 0x200 with data 0x1234.
   -> port 0 is served first.
   -> after ≥1 IDLE cycle, mem_write_o=1, mem_addr_o=0x200, mem_data_o=0x1234.
   -> p1_ack_o pulses once.
3. Both ports request continuously for 4 transactions -> grant order 0,1,0,1; every transaction separated by one IDLE cycle.
4. p1 drops enable 2 cycles into GRANT1 -> mem_enable_o stays 1 until mem_ack_i; p1_ack_o never pulses; next grant proceeds normally.
5. Memory never acks with TIMEOUT_CYC=8 -> err_o=1 exactly 8 cycles into the grant; mem_enable_o stays 1; a late ack still completes the transaction and err_o remains 1.
6. Assert rst_i=0 mid-GRANT0 -> all mem_* outputs, acks and err_o go 0 immediately. After release, a simultaneous request grants port 0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : round-robin arbiter sharing one line-wide memory port between the I-cache (port 0) and D-cache (port 1).
// Latency : a request sampled at edge N drives mem_enable_o after edge N; the ack is forwarded combinationally in the mem_ack_i cycle.
// Backpr. : one transaction in flight; the loser holds its enable until granted; at least one IDLE cycle separates transactions.
//
// Ports:
//   clk_i, rst_i                 clock (rising edge), asynchronous active-low reset
//   pX_enable_i/write_i/addr_i/data_i   requester X line request (enable held until pX_ack_o)
//   pX_data_o, pX_ack_o          read data and 1-cycle done pulse to requester X
//   mem_enable_o/write_o/addr_o/data_o  registered request to memory, held until mem_ack_i
//   mem_data_i, mem_ack_i        memory read data and done pulse
//   err_o                        sticky flag: a grant waited TIMEOUT_CYC cycles without mem_ack_i
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int LINE_W      = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_enable_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [LINE_W-1:0] p0_data_i,
    output logic [LINE_W-1:0] p0_data_o,
    output logic              p0_ack_o,

    input  logic              p1_enable_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [LINE_W-1:0] p1_data_i,
    output logic [LINE_W-1:0] p1_data_o,
    output logic              p1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              err_o
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;  // port served most recently; the other port wins a tie
    logic              aborted;     // granted requester dropped enable; its ack is withheld
    logic [CNT_W-1:0]  cnt;
    logic              cur_enable;

    always_comb begin
        cur_enable = (state == GRANT1) ? p1_enable_i : p0_enable_i;
    end

    // The enable term also covers a drop in the very cycle the memory acks.
    assign p0_ack_o  = (state == GRANT0) && mem_ack_i && p0_enable_i && !aborted;
    assign p1_ack_o  = (state == GRANT1) && mem_ack_i && p1_enable_i && !aborted;
    assign p0_data_o = mem_data_i;
    assign p1_data_o = mem_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            aborted      <= 1'b0;
            cnt          <= '0;
            err_o        <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    aborted <= 1'b0;
                    // Port 0 wins when alone, or on a tie when port 1 was served last.
                    if (p0_enable_i && (!p1_enable_i || last_grant)) begin
                        state        <= GRANT0;
                        last_grant   <= 1'b0;
                        cnt          <= '0;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= p0_write_i;
                        mem_addr_o   <= p0_addr_i;
                        mem_data_o   <= p0_data_i;
                    end else if (p1_enable_i) begin
                        state        <= GRANT1;
                        last_grant   <= 1'b1;
                        cnt          <= '0;
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= p1_write_i;
                        mem_addr_o   <= p1_addr_i;
                        mem_data_o   <= p1_data_i;
                    end
                end
                GRANT0, GRANT1: begin
                    if (mem_ack_i) begin
                        state        <= IDLE;
                        aborted      <= 1'b0;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                    end else begin
                        if (!cur_enable) begin
                            aborted <= 1'b1;
                        end
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                        // Flag on the edge where the count reaches the limit; never cleared here.
                        if (cnt == CNT_MAX - 1'b1) begin
                            err_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    state        <= IDLE;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a behavioural model.
// Latency : checks grant one edge after the request and combinational ack in the mem_ack_i cycle.
// Backpr. : the bench plays both requesters (holding enable until ack) and the memory (random ack delay).
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int LW  = 256;
    localparam int TMO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          p0_enable_i, p0_write_i, p0_ack_o;
    logic [AW-1:0] p0_addr_i;
    logic [LW-1:0] p0_data_i, p0_data_o;
    logic          p1_enable_i, p1_write_i, p1_ack_o;
    logic [AW-1:0] p1_addr_i;
    logic [LW-1:0] p1_data_i, p1_data_o;
    logic          mem_enable_o, mem_write_o, mem_ack_i, err_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_data_o, mem_data_i;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYC(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_enable_i(p0_enable_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
        .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
        .p1_enable_i(p1_enable_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
        .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        p0_enable_i = 1'b0; p0_write_i = 1'b0; p0_addr_i = '0; p0_data_i = '0;
        p1_enable_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = '0; p1_data_i = '0;
        mem_ack_i   = 1'b0; mem_data_i = '0;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b0;
        tick(); tick();
        mem_ack_i = 1'b1;
        #1;
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL rst_mem_enable: got %0b want 0", mem_enable_o); end
        checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %0b want 0", mem_write_o); end
        checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr_o); end
        checks++; if (mem_data_o !== '0) begin errors++; $display("FAIL rst_mem_data: got %h want 0", mem_data_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b want 0", err_o); end
        checks++; if ({p0_ack_o, p1_ack_o} !== 2'b00) begin errors++; $display("FAIL rst_acks: got %b want 00", {p0_ack_o, p1_ack_o}); end
        mem_ack_i = 1'b0;
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_p0_read();
        logic [LW-1:0] pat;
        pat = {32{8'hA5}};
        idle_inputs();
        p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h40;
        tick();
        checks++; if (mem_enable_o !== 1'b1) begin errors++; $display("FAIL rd_grant_en: got %0b want 1", mem_enable_o); end
        checks++; if (mem_addr_o !== 32'h40) begin errors++; $display("FAIL rd_grant_addr: got %h want 40", mem_addr_o); end
        checks++; if (mem_write_o !== 1'b0) begin errors++; $display("FAIL rd_grant_wr: got %0b want 0", mem_write_o); end
        for (int i = 1; i < 10; i++) begin
            tick();
            checks++;
            if ({mem_enable_o, p0_ack_o, p1_ack_o} !== 3'b100) begin
                errors++; $display("FAIL rd_wait cyc %0d: en/ack0/ack1 got %b want 100", i, {mem_enable_o, p0_ack_o, p1_ack_o});
            end
        end
        mem_ack_i = 1'b1; mem_data_i = pat;
        #1;
        checks++; if (p0_ack_o !== 1'b1) begin errors++; $display("FAIL rd_ack0: got %0b want 1", p0_ack_o); end
        checks++; if (p0_data_o !== pat) begin errors++; $display("FAIL rd_data0: got %h want %h", p0_data_o, pat); end
        checks++; if (p1_ack_o !== 1'b0) begin errors++; $display("FAIL rd_ack1: got %0b want 0", p1_ack_o); end
        tick();
        mem_ack_i = 1'b0; p0_enable_i = 1'b0;
        checks++; if ({mem_enable_o, mem_write_o} !== 2'b00) begin errors++; $display("FAIL rd_release: en/wr got %b want 00", {mem_enable_o, mem_write_o}); end
        tick();
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL rd_no_regrant: got %0b want 0", mem_enable_o); end
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        rst_i = 1'b0; #1; rst_i = 1'b1;
        p0_enable_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h100;
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h200; p1_data_i = LW'(32'h1234);
        tick();
        checks++; if ({mem_enable_o, mem_write_o, mem_addr_o} !== {2'b10, 32'h100}) begin
            errors++; $display("FAIL sim_first_grant: en/wr/addr got %b/%b/%h want 1/0/100", mem_enable_o, mem_write_o, mem_addr_o); end
        tick();
        mem_ack_i = 1'b1; mem_data_i = rand_line();
        #1;
        checks++; if ({p0_ack_o, p1_ack_o} !== 2'b10) begin errors++; $display("FAIL sim_ack_first: ack0/ack1 got %b want 10", {p0_ack_o, p1_ack_o}); end
        tick();
        mem_ack_i = 1'b0; p0_enable_i = 1'b0;
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL sim_dead_cycle: got %0b want 0", mem_enable_o); end
        tick();
        checks++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_data_o !== LW'(32'h1234)) begin
            errors++; $display("FAIL sim_second_grant: en/wr/addr/data got %b/%b/%h/%h want 1/1/200/1234", mem_enable_o, mem_write_o, mem_addr_o, mem_data_o); end
        tick();
        mem_ack_i = 1'b1;
        #1;
        checks++; if ({p0_ack_o, p1_ack_o} !== 2'b01) begin errors++; $display("FAIL sim_ack_second: ack0/ack1 got %b want 01", {p0_ack_o, p1_ack_o}); end
        tick();
        mem_ack_i = 1'b0; p1_enable_i = 1'b0;
        tick(); tick();
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL sim_no_regrant: got %0b want 0", mem_enable_o); end
    endtask

    task automatic test_fairness();
        logic [AW-1:0] a0, a1;
        int            exp;
        idle_inputs();
        a0 = 32'h1000; a1 = 32'h2000;
        p0_enable_i = 1'b1; p0_addr_i = a0;
        p1_enable_i = 1'b1; p1_addr_i = a1;
        for (int k = 0; k < 4; k++) begin
            exp = k % 2;
            tick();
            checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== ((exp == 0) ? a0 : a1)) begin
                errors++; $display("FAIL fair_grant %0d: en/addr got %b/%h want port %0d", k, mem_enable_o, mem_addr_o, exp); end
            p0_enable_i = 1'b1; p1_enable_i = 1'b1;
            tick();
            mem_ack_i = 1'b1;
            #1;
            checks++; if ({p1_ack_o, p0_ack_o} !== ((exp == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL fair_ack %0d: ack1/ack0 got %b want port %0d", k, {p1_ack_o, p0_ack_o}, exp); end
            tick();
            mem_ack_i = 1'b0;
            if (exp == 0) p0_enable_i = 1'b0; else p1_enable_i = 1'b0;
            checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL fair_dead %0d: got %0b want 0", k, mem_enable_o); end
        end
        p0_enable_i = 1'b0; p1_enable_i = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [LW-1:0] d;
        idle_inputs();
        p1_enable_i = 1'b1; p1_write_i = 1'b1; p1_addr_i = 32'h80; p1_data_i = rand_line();
        tick();
        checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h80) begin errors++; $display("FAIL ab_grant: en/addr got %b/%h want 1/80", mem_enable_o, mem_addr_o); end
        tick(); tick();
        p1_enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({mem_enable_o, p1_ack_o} !== 2'b10) begin errors++; $display("FAIL ab_hold %0d: en/ack1 got %b want 10", i, {mem_enable_o, p1_ack_o}); end
        end
        mem_ack_i = 1'b1;
        #1;
        checks++; if ({p0_ack_o, p1_ack_o} !== 2'b00) begin errors++; $display("FAIL ab_ack_suppressed: ack0/ack1 got %b want 00", {p0_ack_o, p1_ack_o}); end
        tick();
        mem_ack_i = 1'b0;
        checks++; if (mem_enable_o !== 1'b0) begin errors++; $display("FAIL ab_release: got %0b want 0", mem_enable_o); end
        // A stray ack with nothing granted must go nowhere.
        mem_ack_i = 1'b1;
        #1;
        checks++; if ({p0_ack_o, p1_ack_o} !== 2'b00) begin errors++; $display("FAIL idle_ack: ack0/ack1 got %b want 00", {p0_ack_o, p1_ack_o}); end
        tick();
        mem_ack_i = 1'b0;
        checks++; if ({mem_enable_o, err_o} !== 2'b00) begin errors++; $display("FAIL idle_ack_state: en/err got %b want 00", {mem_enable_o, err_o}); end
        p1_enable_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'hA0;
        tick();
        checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'hA0 || mem_write_o !== 1'b0) begin
            errors++; $display("FAIL ab_next_grant: en/addr/wr got %b/%h/%b want 1/a0/0", mem_enable_o, mem_addr_o, mem_write_o); end
        d = rand_line();
        mem_ack_i = 1'b1; mem_data_i = d;
        #1;
        checks++; if (p1_ack_o !== 1'b1 || p1_data_o !== d) begin errors++; $display("FAIL ab_next_ack: ack1 got %0b want 1, data got %h want %h", p1_ack_o, p1_data_o, d); end
        tick();
        mem_ack_i = 1'b0; p1_enable_i = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic exp;
        idle_inputs();
        p0_enable_i = 1'b1; p0_addr_i = 32'h20;
        tick();
        checks++; if (mem_enable_o !== 1'b1) begin errors++; $display("FAIL to_grant: got %0b want 1", mem_enable_o); end
        for (int i = 1; i <= TMO; i++) begin
            tick();
            exp = (i == TMO);
            checks++; if (err_o !== exp) begin errors++; $display("FAIL to_err cyc %0d: got %0b want %0b", i, err_o, exp); end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({mem_enable_o, err_o} !== 2'b11) begin errors++; $display("FAIL to_wait %0d: en/err got %b want 11", i, {mem_enable_o, err_o}); end
        end
        mem_ack_i = 1'b1; mem_data_i = rand_line();
        #1;
        checks++; if (p0_ack_o !== 1'b1) begin errors++; $display("FAIL to_late_ack: got %0b want 1", p0_ack_o); end
        tick();
        mem_ack_i = 1'b0; p0_enable_i = 1'b0;
        checks++; if ({mem_enable_o, err_o} !== 2'b01) begin errors++; $display("FAIL to_after: en/err got %b want 01", {mem_enable_o, err_o}); end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        p0_enable_i = 1'b1; p0_write_i = 1'b1; p0_addr_i = 32'h3C0; p0_data_i = rand_line();
        tick();
        checks++; if (mem_enable_o !== 1'b1 || mem_write_o !== 1'b1) begin errors++; $display("FAIL rm_grant: en/wr got %b/%b want 1/1", mem_enable_o, mem_write_o); end
        p1_enable_i = 1'b1; p1_addr_i = 32'h7E0;
        tick();
        mem_ack_i = 1'b1;
        rst_i = 1'b0;
        #1;
        checks++; if ({mem_enable_o, mem_write_o} !== 2'b00) begin errors++; $display("FAIL rm_en_wr: got %b want 00", {mem_enable_o, mem_write_o}); end
        checks++; if (mem_addr_o !== '0 || mem_data_o !== '0) begin errors++; $display("FAIL rm_addr_data: got %h/%h want 0/0", mem_addr_o, mem_data_o); end
        checks++; if ({p0_ack_o, p1_ack_o, err_o} !== 3'b000) begin errors++; $display("FAIL rm_ack_err: ack0/ack1/err got %b want 000", {p0_ack_o, p1_ack_o, err_o}); end
        mem_ack_i = 1'b0;
        #2;
        rst_i = 1'b1;
        tick();
        checks++; if (mem_enable_o !== 1'b1 || mem_addr_o !== 32'h3C0) begin errors++; $display("FAIL rm_first_tie: en/addr got %b/%h want 1/3c0", mem_enable_o, mem_addr_o); end
        mem_ack_i = 1'b1;
        #1;
        checks++; if ({p0_ack_o, p1_ack_o} !== 2'b10) begin errors++; $display("FAIL rm_ack: ack0/ack1 got %b want 10", {p0_ack_o, p1_ack_o}); end
        tick();
        idle_inputs();
        tick();
    endtask

    // Randomized traffic: the bench plays both requesters and the memory, and
    // predicts each grant from the round-robin rule over the sampled enables.
    task automatic test_random();
        logic          en [2];
        logic          wr [2];
        logic          dropped [2];
        logic [2:0]    ad [2];
        logic [LW-1:0] dt [2];
        logic [LW-1:0] memarr [8];
        logic [LW-1:0] got_d;
        logic [1:0]    acks;
        logic          busy, cur, last, aborted, e0, e1, ackd, oth;
        int            delay;

        for (int i = 0; i < 8; i++) memarr[i] = rand_line();
        for (int p = 0; p < 2; p++) begin en[p] = 1'b0; wr[p] = 1'b0; ad[p] = '0; dt[p] = '0; end
        idle_inputs();
        rst_i = 1'b0; tick(); rst_i = 1'b1; tick();
        busy = 1'b0; cur = 1'b0; last = 1'b1; aborted = 1'b0; delay = 0;

        for (int c = 0; c < 500; c++) begin
            e0 = en[0]; e1 = en[1]; ackd = mem_ack_i;
            tick();
            mem_ack_i = 1'b0;
            dropped[0] = 1'b0; dropped[1] = 1'b0;
            if (busy && ackd) begin
                busy = 1'b0;
                if (!aborted) begin en[cur] = 1'b0; dropped[cur] = 1'b1; end
            end else if (!busy && (e0 || e1)) begin
                cur = (e0 && e1) ? !last : e1;
                last = cur; busy = 1'b1; aborted = 1'b0;
                delay = int'($urandom_range(0, 5));
                checks++;
                if (mem_addr_o !== AW'({ad[cur], 5'b0}) || mem_write_o !== wr[cur] || (wr[cur] && mem_data_o !== dt[cur])) begin
                    errors++; $display("FAIL rnd_grant c%0d: addr/wr got %h/%b want port %0d addr %h wr %b", c, mem_addr_o, mem_write_o, cur, AW'({ad[cur], 5'b0}), wr[cur]);
                end
            end
            checks++; if (mem_enable_o !== busy) begin errors++; $display("FAIL rnd_enable c%0d: got %0b want %0b", c, mem_enable_o, busy); end

            if (busy && !aborted && $urandom_range(0, 15) == 0) begin
                en[cur] = 1'b0; aborted = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (!en[p] && !dropped[p] && !(busy && cur == p[0]) && $urandom_range(0, 2) == 0) begin
                    en[p] = 1'b1; wr[p] = $urandom_range(0, 1) == 1; ad[p] = 3'($urandom_range(0, 7)); dt[p] = rand_line();
                end
            end
            p0_enable_i = en[0]; p0_write_i = wr[0]; p0_addr_i = AW'({ad[0], 5'b0}); p0_data_i = dt[0];
            p1_enable_i = en[1]; p1_write_i = wr[1]; p1_addr_i = AW'({ad[1], 5'b0}); p1_data_i = dt[1];

            if (busy && delay == 0) begin
                mem_ack_i = 1'b1;
                mem_data_i = wr[cur] ? rand_line() : memarr[ad[cur]];
                if (wr[cur]) memarr[ad[cur]] = dt[cur];
                #1;
                acks = {p1_ack_o, p0_ack_o};
                oth = !cur;
                got_d = cur ? p1_data_o : p0_data_o;
                checks++; if (acks[cur] !== !aborted || acks[oth] !== 1'b0) begin
                    errors++; $display("FAIL rnd_ack c%0d: ack1/ack0 got %b, port %0d aborted=%0b", c, acks, cur, aborted);
                end
                if (!aborted && !wr[cur]) begin
                    checks++; if (got_d !== memarr[ad[cur]]) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, got_d, memarr[ad[cur]]); end
                end
            end else begin
                if (busy) delay--;
                mem_data_i = rand_line();
                #1;
                checks++; if ({p1_ack_o, p0_ack_o} !== 2'b00) begin errors++; $display("FAIL rnd_noack c%0d: got %b want 00", c, {p1_ack_o, p0_ack_o}); end
            end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rnd_err: got %0b want 0", err_o); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_p0_read();
        test_simultaneous();
        test_fairness();
        test_abort();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
